serial_word_deserializer: RTL and testbench

Downstream consumer of the 4-bit serial shift register's output stream. Collects framed serial bits into WIDTH-bit parallel words and presents them on a valid/ready output port through a one-word holding register. Reports framing errors and output overflow with sticky flags. Sits between the shift-register chain and any parallel word consumer.

---
 rtl/shiftreg_pkg.sv | 15 +
 rtl/word_holding_reg.sv | 34 +++
 rtl/serial_word_deserializer.sv | 93 +++++++++
 tb/tb_serial_word_deserializer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// Shared definitions for the serial word deserializer: FSM state encoding and
// the width helper for the collected-bit counter.
package shiftreg_pkg;

   typedef enum logic {
      HUNT    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   // Counter must be able to represent 0..width inclusive.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/word_holding_reg.sv
// One-entry valid/ready output stage. A word arriving while an unconsumed word
// is held (and not being consumed this cycle) is dropped and flagged on drop.
module word_holding_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             drop
);

   logic accept;

   assign accept = load && (!dout_valid || dout_ready);
   assign drop   = load && dout_valid && !dout_ready;

   // A consume and a new load on the same edge keep dout_valid high.
   always_ff @(posedge clk) begin
      if (clear) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (accept) begin
         dout       <= load_data;
         dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_word_deserializer.sv
// Collects framed serial bits into WIDTH-bit words and hands them to a one-word
// holding register; frame errors and dropped words raise sticky flags.
module serial_word_deserializer
   import shiftreg_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                         clk,
   input  logic                         clear,
   input  logic                         sin,
   input  logic                         sin_valid,
   input  logic                         frame,
   output logic [WIDTH-1:0]             dout,
   output logic                         dout_valid,
   input  logic                         dout_ready,
   output logic [cnt_width(WIDTH)-1:0]  bit_cnt,
   output logic                         overflow,
   output logic                         frame_err
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt, base, shifted;
   logic             word_done, frame_err_set, drop;

   always_ff @(posedge clk) begin
      if (clear) begin
         state     <= HUNT;
         bit_cnt   <= '0;
         shreg     <= '0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= cnt_nxt;
         shreg   <= shreg_nxt;
         if (frame_err_set) frame_err <= 1'b1;
         if (drop)          overflow  <= 1'b1;
      end
   end

   // A framed bit always starts from an empty word, discarding any partial one.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = bit_cnt;
      shreg_nxt     = shreg;
      word_done     = 1'b0;
      frame_err_set = 1'b0;
      base          = frame ? '0 : shreg;
      if (MSB_FIRST) shifted = {base[WIDTH-2:0], sin};
      else           shifted = {sin, base[WIDTH-1:1]};

      if (sin_valid) begin
         case (state)
            HUNT: begin
               if (frame) begin
                  shreg_nxt = shifted;
                  cnt_nxt   = CW'(1);
                  state_nxt = COLLECT;
               end
            end
            COLLECT: begin
               shreg_nxt = shifted;
               if (frame) begin
                  frame_err_set = 1'b1;
                  cnt_nxt       = CW'(1);
               end else if (bit_cnt == CW'(WIDTH - 1)) begin
                  word_done = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = HUNT;
               end else begin
                  cnt_nxt = bit_cnt + CW'(1);
               end
            end
         endcase
      end
   end

   word_holding_reg #(.WIDTH(WIDTH)) u_hold (
      .clk        (clk),
      .clear      (clear),
      .load       (word_done),
      .load_data  (shifted),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .drop       (drop)
   );

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a queue-based word model.
module tb_serial_word_deserializer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         clear, sin, sin_valid, frame, dout_ready;
   logic [W-1:0] dout_m, dout_l;
   logic         valid_m, valid_l, ovf_m, ovf_l, ferr_m, ferr_l;
   logic [2:0]   cnt_m, cnt_l;

   int checks = 0;
   int fails  = 0;

   bit     bits[$];
   logic [W-1:0] m_dout_m, m_dout_l;
   bit     m_valid, m_ovf, m_ferr;

   always #5 clk = ~clk;

   serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .clear(clear), .sin(sin), .sin_valid(sin_valid), .frame(frame),
      .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
      .bit_cnt(cnt_m), .overflow(ovf_m), .frame_err(ferr_m));

   serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .clear(clear), .sin(sin), .sin_valid(sin_valid), .frame(frame),
      .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
      .bit_cnt(cnt_l), .overflow(ovf_l), .frame_err(ferr_l));

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Word model: a queue of received bits; a word is the first W bits after a frame.
   task automatic modelStep();
      bit done = 0;
      logic [W-1:0] wm = '0, wl = '0;
      if (clear) begin
         bits.delete();
         m_dout_m = '0; m_dout_l = '0;
         m_valid = 0; m_ovf = 0; m_ferr = 0;
         return;
      end
      if (sin_valid) begin
         if (frame) begin
            if (bits.size() > 0) m_ferr = 1;
            bits.delete();
            bits.push_back(sin);
         end else if (bits.size() > 0) begin
            bits.push_back(sin);
         end
         if (bits.size() == W) begin
            done = 1;
            for (int i = 0; i < W; i++) begin
               wm[W-1-i] = bits[i];
               wl[i]     = bits[i];
            end
            bits.delete();
         end
      end
      if (done) begin
         if (!m_valid || dout_ready) begin
            m_dout_m = wm; m_dout_l = wl; m_valid = 1;
         end else begin
            m_ovf = 1;
         end
      end else if (m_valid && dout_ready) begin
         m_valid = 0;
      end
   endtask

   task automatic checkAll();
      checkOutput("dout_msb",  32'(dout_m),  32'(m_dout_m));
      checkOutput("dout_lsb",  32'(dout_l),  32'(m_dout_l));
      checkOutput("valid_msb", 32'(valid_m), 32'(m_valid));
      checkOutput("valid_lsb", 32'(valid_l), 32'(m_valid));
      checkOutput("bit_cnt",   32'(cnt_m),   32'(bits.size()));
      checkOutput("bit_cnt_l", 32'(cnt_l),   32'(bits.size()));
      checkOutput("overflow",  32'(ovf_m),   32'(m_ovf));
      checkOutput("frame_err", 32'(ferr_l),  32'(m_ferr));
   endtask

   task automatic applyStimulus(input logic clr, input logic v, input logic f,
                                input logic s, input logic rdy);
      clear = clr; sin_valid = v; frame = f; sin = s; dout_ready = rdy;
      @(posedge clk);
      modelStep();
      #1;
      checkAll();
   endtask

   task automatic sendWord(input logic [W-1:0] w, input logic rdy, input int gap);
      for (int i = W - 1; i >= 0; i--) begin
         applyStimulus(0, 1, (i == W - 1), w[i], rdy);
         for (int g = 0; g < gap; g++) applyStimulus(0, 0, 0, 0, rdy);
      end
   endtask

   initial begin
      clear = 1; sin = 0; sin_valid = 0; frame = 0; dout_ready = 0;
      #2;
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("reset_dout",  32'(dout_m),  32'h0);
      checkOutput("reset_valid", 32'(valid_m), 32'h0);

      // 1,0,1,1 arrives MSB-first as 1011 and LSB-first as 1101
      sendWord(4'b1011, 1, 0);
      checkOutput("msb_word", 32'(dout_m),  32'hB);
      checkOutput("lsb_word", 32'(dout_l),  32'hD);
      checkOutput("word_vld", 32'(valid_m), 32'h1);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("vld_1cyc", 32'(valid_m), 32'h0);

      sendWord(4'b1011, 1, 2);
      checkOutput("gap_lsb", 32'(dout_l), 32'hD);

      // overflow: second word dropped while first is held
      applyStimulus(0, 0, 0, 0, 1);
      sendWord(4'hA, 0, 0);
      sendWord(4'h5, 0, 0);
      checkOutput("ovf_hold", 32'(dout_m), 32'hA);
      checkOutput("ovf_flag", 32'(ovf_m),  32'h1);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("ovf_drain", 32'(valid_m), 32'h0);
      checkOutput("ovf_stick", 32'(ovf_m),   32'h1);

      // frame mid-word
      applyStimulus(0, 1, 1, 1, 1);
      applyStimulus(0, 1, 0, 1, 1);
      sendWord(4'b0011, 1, 0);
      checkOutput("ferr_word", 32'(dout_m), 32'h3);
      checkOutput("ferr_flag", 32'(ferr_m), 32'h1);

      // clear mid-word with a held word
      sendWord(4'h9, 0, 0);
      applyStimulus(0, 1, 1, 0, 0);
      applyStimulus(0, 1, 0, 1, 0);
      applyStimulus(1, 1, 0, 1, 0);
      checkOutput("clr_valid", 32'(valid_m), 32'h0);
      checkOutput("clr_ovf",   32'(ovf_m),   32'h0);
      checkOutput("clr_ferr",  32'(ferr_m),  32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 1);
      sendWord(4'hC, 1, 0);
      checkOutput("clr_word", 32'(dout_m), 32'hC);

      // back-to-back words at full rate
      for (int k = 1; k <= 3; k++) begin
         sendWord(W'(k), 1, 0);
         checkOutput("b2b_word", 32'(dout_m), 32'(k));
      end
      checkOutput("b2b_ovf", 32'(ovf_m), 32'h0);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         applyStimulus(($urandom_range(99) < 2), ($urandom_range(99) < 75),
                       ($urandom_range(99) < 20), 1'($urandom), ($urandom_range(99) < 60));
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
